// File: rtl/stage4_alu.sv
// stage4_alu: byte-serial register-file ALU. Walks source/target byte ranges in
// ascending order, one read-read-write triple per byte, and reports carry/zero/error.
module stage4_alu (
   input  logic        ram_clk,
   input  logic        rst,
   input  logic        stage4_exec,
   output logic        stage4_exec_ready,
   input  logic [4:0]  stage4_oper,
   input  logic [15:0] stage4_source_register_start,
   input  logic [15:0] stage4_target_register_start,
   input  logic [15:0] stage4_register_length,
   output logic [8:0]  stage4_reg_read_address,
   input  logic [7:0]  stage4_reg_read_data,
   output logic        stage4_reg_write,
   output logic [8:0]  stage4_reg_write_address,
   output logic [7:0]  stage4_reg_write_data,
   output logic        stage4_carry,
   output logic        stage4_zero,
   output logic        stage4_error
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RD_SRC = 3'd1;
   localparam logic [2:0] ST_RD_TGT = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [4:0] OP_ADD = 5'd1;
   localparam logic [4:0] OP_SUB = 5'd2;
   localparam logic [4:0] OP_AND = 5'd3;
   localparam logic [4:0] OP_OR  = 5'd4;
   localparam logic [4:0] OP_XOR = 5'd5;
   localparam logic [4:0] OP_MOV = 5'd6;

   logic [2:0]  state;
   logic        exec_q;
   logic [4:0]  oper_q;
   logic [8:0]  src_idx;
   logic [8:0]  tgt_idx;
   logic [15:0] remaining;
   logic [7:0]  src_byte;
   logic        cy;
   logic        acc_zero;
   logic        err_pend;

   logic        start;
   logic        start_err;
   logic [16:0] src_end;
   logic [16:0] tgt_end;
   logic [8:0]  sum9;
   logic [8:0]  diff9;
   logic [7:0]  result;
   logic        cy_next;

   assign start   = stage4_exec && !exec_q && (state == ST_IDLE);
   // Range end is start+length; checked in 17 bits so large lengths cannot wrap.
   assign src_end = {1'b0, stage4_source_register_start} + {1'b0, stage4_register_length};
   assign tgt_end = {1'b0, stage4_target_register_start} + {1'b0, stage4_register_length};
   assign start_err = (stage4_oper < OP_ADD) || (stage4_oper > OP_MOV)
                   || (stage4_source_register_start == 16'd0)
                   || (stage4_target_register_start == 16'd0)
                   || (src_end > 17'd512) || (tgt_end > 17'd512);

   assign sum9  = {1'b0, stage4_reg_read_data} + {1'b0, src_byte} + {8'd0, cy};
   assign diff9 = {1'b0, stage4_reg_read_data} - {1'b0, src_byte} - {8'd0, cy};

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      result  = 8'h00;
      cy_next = 1'b0;
      case (oper_q)
         OP_ADD:  begin result = sum9[7:0];  cy_next = sum9[8];  end
         OP_SUB:  begin result = diff9[7:0]; cy_next = diff9[8]; end
         OP_AND:  result = stage4_reg_read_data & src_byte;
         OP_OR:   result = stage4_reg_read_data | src_byte;
         OP_XOR:  result = stage4_reg_read_data ^ src_byte;
         OP_MOV:  result = src_byte;
         default: result = 8'h00;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ram_clk or posedge rst) begin
      if (rst) begin
         state                    <= ST_IDLE;
         exec_q                   <= 1'b1;  // a level held through reset is not a new start
         oper_q                   <= 5'd0;
         src_idx                  <= 9'd0;
         tgt_idx                  <= 9'd0;
         remaining                <= 16'd0;
         src_byte                 <= 8'h00;
         cy                       <= 1'b0;
         acc_zero                 <= 1'b0;
         err_pend                 <= 1'b0;
         stage4_exec_ready        <= 1'b0;
         stage4_reg_read_address  <= 9'd0;
         stage4_reg_write         <= 1'b0;
         stage4_reg_write_address <= 9'd0;
         stage4_reg_write_data    <= 8'h00;
         stage4_carry             <= 1'b0;
         stage4_zero              <= 1'b0;
         stage4_error             <= 1'b0;
      end else begin
         exec_q <= stage4_exec;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  oper_q                  <= stage4_oper;
                  src_idx                 <= stage4_source_register_start[8:0] - 9'd1;
                  tgt_idx                 <= stage4_target_register_start[8:0] - 9'd1;
                  remaining               <= stage4_register_length;
                  stage4_reg_read_address <= stage4_source_register_start[8:0] - 9'd1;
                  cy                      <= 1'b0;
                  acc_zero                <= 1'b1;
                  err_pend                <= start_err;
                  stage4_exec_ready       <= 1'b0;
                  stage4_carry            <= 1'b0;
                  stage4_zero             <= 1'b0;
                  stage4_error            <= 1'b0;
                  state <= (start_err || stage4_register_length == 16'd0) ? ST_DONE : ST_RD_SRC;
               end
            end
            ST_RD_SRC: begin
               src_byte                <= stage4_reg_read_data;
               stage4_reg_read_address <= tgt_idx;
               state                   <= ST_RD_TGT;
            end
            ST_RD_TGT: begin
               stage4_reg_write         <= 1'b1;
               stage4_reg_write_address <= tgt_idx;
               stage4_reg_write_data    <= result;
               cy                       <= cy_next;
               acc_zero                 <= acc_zero && (result == 8'h00);
               state                    <= ST_WRITE;
            end
            ST_WRITE: begin
               stage4_reg_write <= 1'b0;
               if (remaining == 16'd1) begin
                  state <= ST_DONE;
               end else begin
                  remaining               <= remaining - 16'd1;
                  src_idx                 <= src_idx + 9'd1;
                  tgt_idx                 <= tgt_idx + 9'd1;
                  stage4_reg_read_address <= src_idx + 9'd1;
                  state                   <= ST_RD_SRC;
               end
            end
            ST_DONE: begin
               stage4_exec_ready <= 1'b1;
               stage4_error      <= err_pend;
               stage4_zero       <= !err_pend && acc_zero;
               stage4_carry      <= !err_pend && (oper_q == OP_ADD || oper_q == OP_SUB) && cy;
               state             <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage4_alu.sv
// Self-checking bench for stage4_alu: a 512-byte register-file model and a
// scoreboard of expected writes filled by a reference model before each operation.
module tb_stage4_alu;

   logic        ram_clk = 1'b0;
   logic        rst;
   logic        stage4_exec;
   logic        stage4_exec_ready;
   logic [4:0]  stage4_oper;
   logic [15:0] stage4_source_register_start;
   logic [15:0] stage4_target_register_start;
   logic [15:0] stage4_register_length;
   logic [8:0]  stage4_reg_read_address;
   logic [7:0]  stage4_reg_read_data;
   logic        stage4_reg_write;
   logic [8:0]  stage4_reg_write_address;
   logic [7:0]  stage4_reg_write_data;
   logic        stage4_carry;
   logic        stage4_zero;
   logic        stage4_error;

   typedef struct {
      logic [8:0] addr;
      logic [7:0] data;
   } wr_t;

   logic [7:0] mem [512];
   wr_t        exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_writes = 0;

   always #5 ram_clk = ~ram_clk;

   assign stage4_reg_read_data = mem[stage4_reg_read_address];

   stage4_alu dut (
      .ram_clk                      (ram_clk),
      .rst                          (rst),
      .stage4_exec                  (stage4_exec),
      .stage4_exec_ready            (stage4_exec_ready),
      .stage4_oper                  (stage4_oper),
      .stage4_source_register_start (stage4_source_register_start),
      .stage4_target_register_start (stage4_target_register_start),
      .stage4_register_length       (stage4_register_length),
      .stage4_reg_read_address      (stage4_reg_read_address),
      .stage4_reg_read_data         (stage4_reg_read_data),
      .stage4_reg_write             (stage4_reg_write),
      .stage4_reg_write_address     (stage4_reg_write_address),
      .stage4_reg_write_data        (stage4_reg_write_data),
      .stage4_carry                 (stage4_carry),
      .stage4_zero                  (stage4_zero),
      .stage4_error                 (stage4_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Register file write port plus scoreboard pop for each strobe.
   always @(posedge ram_clk) begin
      if (stage4_reg_write === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(exp_q.size()), 32'd1);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(stage4_reg_write_address), 32'(e.addr));
            check("write_data", 32'(stage4_reg_write_data), 32'(e.data));
         end
         mem[stage4_reg_write_address] <= stage4_reg_write_data;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(stage4_exec_ready), 32'd0);
      check({tag, "_wr"},    32'(stage4_reg_write), 32'd0);
      check({tag, "_raddr"}, 32'(stage4_reg_read_address), 32'd0);
      check({tag, "_waddr"}, 32'(stage4_reg_write_address), 32'd0);
      check({tag, "_wdata"}, 32'(stage4_reg_write_data), 32'd0);
      check({tag, "_flags"}, {29'd0, stage4_carry, stage4_zero, stage4_error}, 32'd0);
   endtask

   // Model the operation, push expected writes, run it, then compare timing and flags.
   task automatic run_op(input logic [4:0] op, input int src, input int tgt, input int len,
                         input int pulse_at, input bit hold);
      logic [7:0] m [512];
      logic [8:0] r9;
      logic [7:0] s, t, r;
      logic       ecy, ez, eerr;
      int         exp_edge, got_edge, w0;
      wr_t        w;
      m = mem;
      eerr = (op < 5'd1) || (op > 5'd6) || (src == 0) || (tgt == 0)
          || (src + len - 1 > 511) || (tgt + len - 1 > 511);
      ecy = 1'b0;
      ez  = 1'b1;
      if (!eerr) begin
         for (int i = 0; i < len; i++) begin
            s = m[src - 1 + i];
            t = m[tgt - 1 + i];
            r9 = 9'd0;
            case (op)
               5'd1: begin r9 = {1'b0, t} + {1'b0, s} + {8'd0, ecy}; r = r9[7:0]; ecy = r9[8]; end
               5'd2: begin r9 = {1'b0, t} - {1'b0, s} - {8'd0, ecy}; r = r9[7:0]; ecy = r9[8]; end
               5'd3: r = t & s;
               5'd4: r = t | s;
               5'd5: r = t ^ s;
               default: r = s;
            endcase
            if (r != 8'h00) ez = 1'b0;
            m[tgt - 1 + i] = r;
            w.addr = 9'(tgt - 1 + i);
            w.data = r;
            exp_q.push_back(w);
         end
      end
      exp_edge = (eerr || len == 0) ? 1 : 3 * len + 1;
      w0 = n_writes;

      @(negedge ram_clk);
      stage4_oper                  = op;
      stage4_source_register_start = 16'(src);
      stage4_target_register_start = 16'(tgt);
      stage4_register_length       = 16'(len);
      stage4_exec                  = 1'b1;
      @(posedge ram_clk);  // E0
      #1;
      check("ready_drop_e0", 32'(stage4_exec_ready), 32'd0);
      check("flags_clear_e0", {29'd0, stage4_carry, stage4_zero, stage4_error}, 32'd0);
      if (!hold) stage4_exec = 1'b0;
      stage4_oper = 5'd0;  // operands must have been latched at E0
      stage4_register_length = 16'hFFFF;
      got_edge = -1;
      for (int k = 1; k <= 3 * len + 20; k++) begin
         @(posedge ram_clk);
         #1;
         if (k == pulse_at) stage4_exec = 1'b1;
         if (k == pulse_at + 1) stage4_exec = 1'b0;
         if (stage4_exec_ready === 1'b1) begin
            got_edge = k;
            break;
         end
      end
      check("ready_edge", 32'(got_edge), 32'(exp_edge));
      check("error", 32'(stage4_error), 32'(eerr));
      check("carry", 32'(stage4_carry), eerr ? 32'd0 : 32'(ecy));
      if (!eerr) check("zero", 32'(stage4_zero), 32'(ez));
      check("write_count", 32'(n_writes - w0), eerr ? 32'd0 : 32'(len));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      if (hold) begin
         repeat (6) @(posedge ram_clk);
         #1;
         check("hold_no_retrigger_ready", 32'(stage4_exec_ready), 32'd1);
         check("hold_no_retrigger_writes", 32'(n_writes - w0), 32'(len));
      end
      stage4_exec = 1'b0;
      exp_q.delete();
      @(negedge ram_clk);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
      rst                          = 1'b1;
      stage4_exec                  = 1'b0;
      stage4_oper                  = 5'd0;
      stage4_source_register_start = 16'd0;
      stage4_target_register_start = 16'd0;
      stage4_register_length       = 16'd0;
      #12;
      check_reset_outputs("reset");
      @(negedge ram_clk);
      rst = 1'b0;
      repeat (2) @(negedge ram_clk);

      // ADD with carry across two bytes, ready at E7
      mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'h01; mem[3] = 8'h00;
      run_op(5'd1, 3, 1, 2, 0, 1'b0);
      check("add_reg1", 32'(mem[0]), 32'h00);
      check("add_reg2", 32'(mem[1]), 32'h01);

      // SUB with borrow out
      mem[9] = 8'h00; mem[10] = 8'h01;
      run_op(5'd2, 11, 10, 1, 0, 1'b0);
      check("sub_result", 32'(mem[9]), 32'hFF);

      // XOR of a range with itself
      mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'h56;
      run_op(5'd5, 5, 5, 3, 0, 1'b0);

      // Errors and length 0
      run_op(5'd9, 3, 1, 2, 0, 1'b0);
      run_op(5'd1, 3, 510, 4, 0, 1'b0);
      run_op(5'd1, 0, 1, 1, 0, 1'b0);
      run_op(5'd1, 3, 1, 0, 0, 1'b0);

      // Overlapping MOV: earlier writes feed later reads
      mem[19] = 8'hAB; mem[20] = 8'h11; mem[21] = 8'h22; mem[22] = 8'h33;
      run_op(5'd6, 20, 21, 3, 0, 1'b0);
      check("overlap_last", 32'(mem[22]), 32'hAB);

      // Ignored second exec pulse during length 4; then exec held high
      run_op(5'd4, 100, 200, 4, 4, 1'b0);
      run_op(5'd3, 120, 220, 2, 0, 1'b1);

      // Assorted random operations
      for (int j = 0; j < 6; j++)
         run_op(5'($urandom_range(1, 6)), $urandom_range(100, 300), $urandom_range(300, 400),
                $urandom_range(1, 5), 0, 1'b0);

      // Reset after the first WRITE of a length-3 MOV
      mem[39] = 8'hA1; mem[40] = 8'hA2; mem[41] = 8'hA3;
      mem[49] = 8'h00; mem[50] = 8'h00; mem[51] = 8'h00;
      exp_q.push_back('{addr: 9'd49, data: 8'hA1});
      @(negedge ram_clk);
      stage4_oper                  = 5'd6;
      stage4_source_register_start = 16'd40;
      stage4_target_register_start = 16'd50;
      stage4_register_length       = 16'd3;
      stage4_exec                  = 1'b1;
      @(posedge ram_clk);
      #1 stage4_exec = 1'b0;
      repeat (3) @(posedge ram_clk);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midop_reset");
      repeat (2) @(negedge ram_clk);
      rst = 1'b0;
      repeat (8) @(negedge ram_clk);
      check("abort_byte0", 32'(mem[49]), 32'hA1);
      check("abort_byte1", 32'(mem[50]), 32'h00);
      check("abort_byte2", 32'(mem[51]), 32'h00);
      check("abort_queue", 32'(exp_q.size()), 32'd0);
      check("abort_no_ready", 32'(stage4_exec_ready), 32'd0);
      run_op(5'd6, 40, 50, 3, 0, 1'b0);
      check("rerun_byte2", 32'(mem[51]), 32'hA3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
